scope_capture_buffer: RTL and testbench

SCOPE_CAPTURE_BUFFER -- requirements
Module: scope_capture_buffer

---
 rtl/scope_capture_buffer.sv | 171 +++++++++++++++++
 tb/tb_scope_capture_buffer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scope_capture_buffer.sv
// Purpose: triggered capture buffer. It holds a DEPTH-sample window made of
//          pre_len samples before the trigger, the trigger sample, and the
//          samples that follow it.
// Latency: a sample is written on the edge it is presented. rd_data/rd_valid
//          appear one cycle after rd_en.
// Backpressure: none. Samples that arrive in IDLE or DONE are dropped, and
//          reads are honoured only in DONE.
// Ports:   clk/resetn clock and asynchronous active-low reset;
//          arm/pre_len start (or restart) a capture;
//          din/din_valid/trig/force_trig sample stream and trigger inputs;
//          busy/done/start_ptr capture status;
//          rd_en/rd_addr/rd_data/rd_valid window readback, offset from start_ptr.
module scope_capture_buffer #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              arm,
   input  logic [ADDR_W-1:0] pre_len,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   input  logic              trig,
   input  logic              force_trig,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] start_ptr,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid
);

   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PRE   = 3'd1;
   localparam logic [2:0] S_ARMED = 3'd2;
   localparam logic [2:0] S_POST  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] start_ptr_q, start_ptr_d;
   logic [ADDR_W-1:0] fill_q, fill_d;
   logic [ADDR_W-1:0] post_rem_q, post_rem_d;
   logic [ADDR_W-1:0] pre_lat_q, pre_lat_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              rd_valid_q;
   logic [DATA_W-1:0] rd_data_q;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              capturing;
   logic              wr_en;
   logic              rd_fire;
   logic [ADDR_W-1:0] rd_ptr;

   assign capturing = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
   // arm takes priority over a coincident sample, so that sample is not stored.
   assign wr_en     = capturing && din_valid && !arm;
   assign rd_fire   = rd_en && (state_q == S_DONE);
   assign rd_ptr    = start_ptr_q + rd_addr;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      start_ptr_d = start_ptr_q;
      fill_d      = fill_q;
      post_rem_d  = post_rem_q;
      pre_lat_d   = pre_lat_q;

      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end

      if (arm) begin
         // The port width already caps pre_len at DEPTH-1, so no clamp is needed.
         state_d   = S_PRE;
         pre_lat_d = pre_len;
         fill_d    = '0;
      end else begin
         case (state_q)
            S_PRE: begin
               if (pre_lat_q == '0) begin
                  state_d = S_ARMED;
               end else if (wr_en) begin
                  fill_d = fill_q + ADDR_W'(1);
                  if (fill_d == pre_lat_q) begin
                     state_d = S_ARMED;
                  end
               end
            end
            S_ARMED: begin
               if (wr_en && (trig || force_trig)) begin
                  // The window begins pre_lat samples behind the trigger sample.
                  // The post count fills out the remaining DEPTH-1-pre_lat slots.
                  start_ptr_d = wr_ptr_q - pre_lat_q;
                  post_rem_d  = {ADDR_W{1'b1}} - pre_lat_q;
                  state_d     = (post_rem_d == '0) ? S_DONE : S_POST;
               end
            end
            S_POST: begin
               if (wr_en) begin
                  post_rem_d = post_rem_q - ADDR_W'(1);
                  if (post_rem_q == ADDR_W'(1)) begin
                     state_d = S_DONE;
                  end
               end
            end
            S_IDLE, S_DONE: begin
            end
            default: state_d = S_IDLE;
         endcase
      end

      // Decoding the next state keeps busy/done in step with state_q.
      busy_d = (state_d == S_PRE) || (state_d == S_ARMED) || (state_d == S_POST);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         start_ptr_q <= '0;
         fill_q      <= '0;
         post_rem_q  <= '0;
         pre_lat_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         start_ptr_q <= start_ptr_d;
         fill_q      <= fill_d;
         post_rem_q  <= post_rem_d;
         pre_lat_q   <= pre_lat_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // The sample store is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= din;
      end
   end

   // Registered read port. rd_data holds its value when no read completes.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_fire;
         if (rd_fire) begin
            rd_data_q <= mem[rd_ptr];
         end
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign start_ptr = start_ptr_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_scope_capture_buffer.sv
// Purpose: directed self-checking bench for scope_capture_buffer (ADDR_W=4, DATA_W=8).
// Latency: inputs are driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; the bench drives the stream freely.
module tb_scope_capture_buffer;

   logic       clk = 1'b0;
   logic       resetn = 1'b1;
   logic       arm = 1'b0;
   logic [3:0] pre_len = '0;
   logic [7:0] din = '0;
   logic       din_valid = 1'b0;
   logic       trig = 1'b0;
   logic       force_trig = 1'b0;
   logic       busy;
   logic       done;
   logic [3:0] start_ptr;
   logic       rd_en = 1'b0;
   logic [3:0] rd_addr = '0;
   logic [7:0] rd_data;
   logic       rd_valid;

   int n_checks = 0;
   int n_pass   = 0;

   scope_capture_buffer #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk(clk), .resetn(resetn), .arm(arm), .pre_len(pre_len),
      .din(din), .din_valid(din_valid), .trig(trig), .force_trig(force_trig),
      .busy(busy), .done(done), .start_ptr(start_ptr),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      resetn = 1'b0;
      #2;
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   task automatic do_arm(input logic [3:0] len);
      arm = 1'b1; pre_len = len; din_valid = 1'b0; trig = 1'b0; force_trig = 1'b0;
      tick;
      arm = 1'b0;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      #2;
      n_checks++;
      if ({busy, done, rd_valid, start_ptr, rd_data} !== 15'd0)
         $display("FAIL reset_outputs got busy=%0b done=%0b rd_valid=%0b start_ptr=%0d rd_data=%0d want all 0",
                  busy, done, rd_valid, start_ptr, rd_data);
      else n_pass++;
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   // Trigger on din=10 with pre_len=4. The window is 6..21 and start_ptr is 6.
   task automatic test_basic;
      do_reset;
      do_arm(4'd4);
      for (int i = 0; i <= 25; i++) begin
         din = 8'(i); din_valid = 1'b1; trig = (i == 10);
         tick;
         if (i == 5) begin
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0)
               $display("FAIL basic_busy got busy=%0b done=%0b want 1/0", busy, done);
            else n_pass++;
         end
         if (i == 20) begin
            n_checks++;
            if (done !== 1'b0) $display("FAIL basic_done_early got %0b want 0", done);
            else n_pass++;
         end
         if (i == 21) begin
            n_checks++;
            if (done !== 1'b1 || busy !== 1'b0 || start_ptr !== 4'd6)
               $display("FAIL basic_done got done=%0b busy=%0b start_ptr=%0d want 1/0/6", done, busy, start_ptr);
            else n_pass++;
         end
      end
      din_valid = 1'b0; trig = 1'b0;
      // din 22..25 arrived in DONE and must not have overwritten the window.
      for (int k = 0; k < 16; k++) begin
         rd_en = 1'b1; rd_addr = 4'(k);
         tick;
         n_checks++;
         if (rd_valid !== 1'b1 || rd_data !== 8'(6 + k))
            $display("FAIL basic_read[%0d] got valid=%0b data=%0d want 1/%0d", k, rd_valid, rd_data, 6 + k);
         else n_pass++;
      end
      rd_en = 1'b1; rd_addr = 4'd4;
      tick;
      n_checks++;
      if (rd_data !== 8'd10) $display("FAIL basic_trig_sample got %0d want 10", rd_data);
      else n_pass++;
      rd_en = 1'b0;
      tick;
      n_checks++;
      if (rd_valid !== 1'b0 || rd_data !== 8'd10)
         $display("FAIL basic_read_hold got valid=%0b data=%0d want 0/10", rd_valid, rd_data);
      else n_pass++;
   endtask

   // A trigger during PRE_FILL is ignored. The real trigger is on din=7, so the window is 3..18.
   task automatic test_pretrig_ignored;
      do_reset;
      do_arm(4'd4);
      for (int i = 0; i <= 22; i++) begin
         din = 8'(i); din_valid = 1'b1; trig = (i == 1 || i == 2 || i == 7);
         tick;
         if (i == 17) begin
            n_checks++;
            if (done !== 1'b0) $display("FAIL pretrig_done_early got %0b want 0", done);
            else n_pass++;
         end
         if (i == 18) begin
            n_checks++;
            if (done !== 1'b1 || start_ptr !== 4'd3)
               $display("FAIL pretrig_done got done=%0b start_ptr=%0d want 1/3", done, start_ptr);
            else n_pass++;
         end
      end
      din_valid = 1'b0; trig = 1'b0;
      for (int k = 0; k < 16; k += 5) begin
         rd_en = 1'b1; rd_addr = 4'(k);
         tick;
         n_checks++;
         if (rd_valid !== 1'b1 || rd_data !== 8'(3 + k))
            $display("FAIL pretrig_read[%0d] got valid=%0b data=%0d want 1/%0d", k, rd_valid, rd_data, 3 + k);
         else n_pass++;
      end
      rd_en = 1'b1; rd_addr = 4'd4;
      tick;
      n_checks++;
      if (rd_data !== 8'd7) $display("FAIL pretrig_trig_sample got %0d want 7", rd_data);
      else n_pass++;
      rd_en = 1'b0;
   endtask

   // Maximum pre-trigger length: 15 is the largest value a 4-bit pre_len can carry.
   // A trigger on din=30 gives the window 15..30, and DONE follows the trigger write directly.
   task automatic test_clamp;
      do_reset;
      do_arm(4'd15);
      for (int i = 0; i <= 33; i++) begin
         din = 8'(i); din_valid = 1'b1; trig = (i == 30);
         tick;
         if (i == 29) begin
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b1)
               $display("FAIL clamp_armed got done=%0b busy=%0b want 0/1", done, busy);
            else n_pass++;
         end
         if (i == 30) begin
            n_checks++;
            if (done !== 1'b1 || busy !== 1'b0 || start_ptr !== 4'd15)
               $display("FAIL clamp_done got done=%0b busy=%0b start_ptr=%0d want 1/0/15", done, busy, start_ptr);
            else n_pass++;
         end
      end
      din_valid = 1'b0; trig = 1'b0;
      for (int k = 0; k < 16; k += 5) begin
         rd_en = 1'b1; rd_addr = 4'(k);
         tick;
         n_checks++;
         if (rd_valid !== 1'b1 || rd_data !== 8'(15 + k))
            $display("FAIL clamp_read[%0d] got valid=%0b data=%0d want 1/%0d", k, rd_valid, rd_data, 15 + k);
         else n_pass++;
      end
      rd_en = 1'b0;
   endtask

   // din_valid alternates, starting high. The 6th valid sample carries force_trig, and pre_len is 2.
   // Valid sample v has value 0x40+v, so the window is v3..v18.
   task automatic test_gaps;
      do_reset;
      do_arm(4'd2);
      for (int c = 0; c <= 40; c++) begin
         din_valid  = (c % 2 == 0);
         din        = din_valid ? 8'(8'h40 + c / 2) : 8'hEE;
         force_trig = din_valid && (c / 2 == 5);
         tick;
         if (c == 35) begin
            n_checks++;
            if (done !== 1'b0) $display("FAIL gaps_done_early got %0b want 0", done);
            else n_pass++;
         end
         if (c == 36) begin
            n_checks++;
            if (done !== 1'b1 || start_ptr !== 4'd3)
               $display("FAIL gaps_done got done=%0b start_ptr=%0d want 1/3", done, start_ptr);
            else n_pass++;
         end
      end
      din_valid = 1'b0; force_trig = 1'b0;
      for (int k = 0; k < 16; k++) begin
         rd_en = 1'b1; rd_addr = 4'(k);
         tick;
         n_checks++;
         if (rd_valid !== 1'b1 || rd_data !== 8'(8'h43 + k))
            $display("FAIL gaps_read[%0d] got valid=%0b data=%0h want 1/%0h", k, rd_valid, rd_data, 8'h43 + k);
         else n_pass++;
      end
      rd_en = 1'b0;
   endtask

   // This scenario covers four things:
   //   arm coinciding with a read in DONE;
   //   arm arriving mid-POST;
   //   a read outside DONE;
   //   asynchronous reset in the middle of PRE_FILL.
   task automatic test_abort;
      do_reset;
      do_arm(4'd2);
      for (int i = 0; i <= 19; i++) begin
         din = 8'(i); din_valid = 1'b1; trig = (i == 6);
         tick;
      end
      din_valid = 1'b0; trig = 1'b0;
      n_checks++;
      if (done !== 1'b1 || start_ptr !== 4'd4)
         $display("FAIL abort_first_done got done=%0b start_ptr=%0d want 1/4", done, start_ptr);
      else n_pass++;
      rd_en = 1'b1; rd_addr = 4'd3;
      tick;
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'd7)
         $display("FAIL abort_read got valid=%0b data=%0d want 1/7", rd_valid, rd_data);
      else n_pass++;
      arm = 1'b1; pre_len = 4'd2; rd_en = 1'b1; rd_addr = 4'd5;
      tick;
      arm = 1'b0; rd_en = 1'b0;
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'd9 || busy !== 1'b1 || done !== 1'b0)
         $display("FAIL arm_with_read got valid=%0b data=%0d busy=%0b done=%0b want 1/9/1/0",
                  rd_valid, rd_data, busy, done);
      else n_pass++;
      // Second capture: samples 50 and 51 pre-fill, and 52 triggers, giving start_ptr = 6-2 = 4.
      for (int i = 50; i <= 53; i++) begin
         din = 8'(i); din_valid = 1'b1; trig = (i == 52);
         tick;
      end
      din_valid = 1'b0; trig = 1'b0;
      do_arm(4'd3);
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0)
         $display("FAIL arm_mid_post got busy=%0b done=%0b want 1/0", busy, done);
      else n_pass++;
      din = 8'd60; din_valid = 1'b1;
      tick;
      din_valid = 1'b0;
      rd_en = 1'b1; rd_addr = 4'd0;
      tick;
      rd_en = 1'b0;
      n_checks++;
      if (rd_valid !== 1'b0 || rd_data !== 8'd9 || start_ptr !== 4'd4)
         $display("FAIL read_not_done got valid=%0b data=%0d start_ptr=%0d want 0/9/4", rd_valid, rd_data, start_ptr);
      else n_pass++;
      resetn = 1'b0;
      #2;
      n_checks++;
      if ({busy, done, rd_valid, start_ptr, rd_data} !== 15'd0)
         $display("FAIL async_reset got busy=%0b done=%0b rd_valid=%0b start_ptr=%0d rd_data=%0d want all 0",
                  busy, done, rd_valid, start_ptr, rd_data);
      else n_pass++;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      // After reset the block sits in IDLE until armed again.
      din = 8'd70; din_valid = 1'b1; trig = 1'b1; rd_en = 1'b1;
      tick;
      tick;
      din_valid = 1'b0; trig = 1'b0; rd_en = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0)
         $display("FAIL idle_after_reset got busy=%0b done=%0b rd_valid=%0b want 0/0/0", busy, done, rd_valid);
      else n_pass++;
   endtask

   initial begin
      #1;
      test_reset;
      test_basic;
      test_pretrig_ignored;
      test_clamp;
      test_gaps;
      test_abort;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
